// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Arbitrates a single-port RAM between an instruction-fetch port and a
//   data port. Data requests win over fetches. A granted request holds the
//   RAM strobes until ramstate reports ACCESS, and then the block gives a
//   one-cycle hit pulse. If the request is dropped before ACCESS, the grant
//   is abandoned without a hit. If the RAM reports ERROR, or the wait passes
//   TIMEOUT cycles, the block locks into a sticky fault state that only RST
//   clears.
//
// Ports
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   iREN, iaddr         fetch request and address
//   iload, ihit         registered fetched word, one-cycle fetch-done pulse
//   dREN, dWEN          data read / write requests (both high counts as a write)
//   daddr, dstore       data address and write data
//   dload, dhit         registered read word, one-cycle data-done pulse
//   ramREN, ramWEN      RAM strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   fault               sticky error flag
module memory_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  // state | meaning
  // IDLE  | no grant; ramstate ignored
  // IREQ  | fetch granted, strobing RAM until ACCESS
  // DREQ  | data access granted, strobing RAM until ACCESS
  // RESP  | one-cycle hit for the completed request
  // ERR   | RAM error or timeout; locked until RST
  typedef enum logic [2:0] {IDLE, IREQ, DREQ, RESP, ERR} state_t;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam logic [7:0] TMO       = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic       resp_d;   // the grant in flight is a data request
  logic [7:0] wcnt;
  logic       access;
  logic       stall_fail;

  assign access     = (ramstate == RS_ACCESS);
  // Evaluated only after ACCESS and abort have been ruled out.
  assign stall_fail = (ramstate == RS_ERROR) || (wcnt == TMO);

  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: begin
        if (dREN || dWEN)
          state_nxt = DREQ;
        else if (iREN)
          state_nxt = IREQ;
      end
      IREQ: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (access)
          state_nxt = RESP;
        else if (!iREN)
          state_nxt = IDLE;
        else if (stall_fail)
          state_nxt = ERR;
      end
      DREQ: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (access)
          state_nxt = RESP;
        else if (!dREN && !dWEN)
          state_nxt = IDLE;
        else if (stall_fail)
          state_nxt = ERR;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      resp_d <= 1'b0;
      wcnt   <= '0;
      iload  <= '0;
      dload  <= '0;
      fault  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Latch which port is being granted so RESP knows which hit to raise.
      if (state == IDLE)
        resp_d <= dREN | dWEN;
      // Counter is held at zero outside the request states so every grant
      // starts from zero; it saturates instead of wrapping.
      if (state == IREQ || state == DREQ) begin
        if (!access && wcnt != 8'hFF)
          wcnt <= wcnt + 8'd1;
      end else begin
        wcnt <= '0;
      end
      if (state == IREQ && access)
        iload <= ramload;
      if (state == DREQ && access && dREN && !dWEN)
        dload <= ramload;
      if (state_nxt == ERR)
        fault <= 1'b1;
    end
  end

  assign ihit = (state == RESP) && !resp_d;
  assign dhit = (state == RESP) &&  resp_d;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam logic [1:0] F = 2'b00, B = 2'b01, A = 2'b10, E = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, fault;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .fault(fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  req;     // {iREN, dREN, dWEN}
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic [1:0]  estb;    // {ramREN, ramWEN}
    logic [31:0] eaddr, estore;
    logic [1:0]  ehit;    // {ihit, dhit}
    logic [31:0] eil, edl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] req, input logic [31:0] ia, da, ds, rl,
                     input logic [1:0] rs, input logic [1:0] estb,
                     input logic [31:0] eaddr, estore, input logic [1:0] ehit,
                     input logic [31:0] eil, edl);
    vec_t v;
    v.req = req; v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.estb = estb; v.eaddr = eaddr; v.estore = estore; v.ehit = ehit;
    v.eil = eil; v.edl = edl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = F;
  endtask

  initial begin
    int n;
    bit seen;
    RST = 1;
    idle_inputs();

    // table: one row per cycle, inputs applied after the edge, checked mid-cycle
    //   fetch, ACCESS on 2nd strobe cycle
    add(3'b100, 32'h40, 0, 0, 0,            F, 2'b00, 0,     0, 2'b00, 0, 0);
    add(3'b100, 32'h40, 0, 0, 0,            B, 2'b10, 32'h40, 0, 2'b00, 0, 0);
    add(3'b100, 32'h40, 0, 0, 32'h8C220004, A, 2'b10, 32'h40, 0, 2'b00, 0, 0);
    add(3'b000, 32'h40, 0, 0, 0,            F, 2'b00, 0,     0, 2'b10, 32'h8C220004, 0);
    add(3'b000, 0, 0, 0, 0,                 E, 2'b00, 0,     0, 2'b00, 32'h8C220004, 0);
    //   data beats fetch, one IDLE cycle, then the fetch
    add(3'b110, 32'h44, 32'h100, 0, 0,            F, 2'b00, 0, 0, 2'b00, 32'h8C220004, 0);
    add(3'b110, 32'h44, 32'h100, 0, 32'h11112222, A, 2'b10, 32'h100, 0, 2'b00, 32'h8C220004, 0);
    add(3'b100, 32'h44, 32'h100, 0, 0,            F, 2'b00, 0, 0, 2'b01, 32'h8C220004, 32'h11112222);
    add(3'b100, 32'h44, 0, 0, 0,                  F, 2'b00, 0, 0, 2'b00, 32'h8C220004, 32'h11112222);
    add(3'b100, 32'h44, 0, 0, 32'hCAFEF00D,       A, 2'b10, 32'h44, 0, 2'b00, 32'h8C220004, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                       F, 2'b00, 0, 0, 2'b10, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                       F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    //   write, ACCESS after 3 BUSY cycles
    add(3'b001, 0, 32'h200, 32'hDEADBEEF, 0,            F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    for (int i = 0; i < 3; i++)
      add(3'b001, 0, 32'h200, 32'hDEADBEEF, 0,          B, 2'b01, 32'h200, 32'hDEADBEEF, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b001, 0, 32'h200, 32'hDEADBEEF, 32'h55555555, A, 2'b01, 32'h200, 32'hDEADBEEF, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                             F, 2'b00, 0, 0, 2'b01, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                             F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    //   read+write together is a write
    add(3'b011, 0, 32'h300, 32'hABCD, 0,            F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b011, 0, 32'h300, 32'hABCD, 32'h99999999, A, 2'b01, 32'h300, 32'hABCD, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                         F, 2'b00, 0, 0, 2'b01, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                         F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    //   fetch abort in 2nd IREQ cycle
    add(3'b100, 32'h80, 0, 0, 0,            F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b100, 32'h80, 0, 0, 0,            B, 2'b10, 32'h80, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 32'h80, 0, 0, 32'h12345678, B, 2'b10, 32'h80, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 32'h12345678,      A, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);
    add(3'b000, 0, 0, 0, 0,                 F, 2'b00, 0, 0, 2'b00, 32'hCAFEF00D, 32'h11112222);

    // reset state
    cyc(); cyc();
    @(negedge CLK);
    chk("reset hits", {30'd0, ihit, dhit}, 0);
    chk("reset strobes", {30'd0, ramREN, ramWEN}, 0);
    chk("reset fault", {31'd0, fault}, 0);
    chk("reset iload", iload, 0);
    chk("reset dload", dload, 0);

    cyc();
    RST = 0;
    foreach (vecs[k]) begin
      {iREN, dREN, dWEN} = vecs[k].req;
      iaddr = vecs[k].ia; daddr = vecs[k].da; dstore = vecs[k].ds;
      ramload = vecs[k].rl; ramstate = vecs[k].rs;
      @(negedge CLK);
      chk($sformatf("row%0d strobes", k), {30'd0, ramREN, ramWEN}, {30'd0, vecs[k].estb});
      chk($sformatf("row%0d ramaddr", k), ramaddr, vecs[k].eaddr);
      chk($sformatf("row%0d ramstore", k), ramstore, vecs[k].estore);
      chk($sformatf("row%0d hits", k), {30'd0, ihit, dhit}, {30'd0, vecs[k].ehit});
      chk($sformatf("row%0d iload", k), iload, vecs[k].eil);
      chk($sformatf("row%0d dload", k), dload, vecs[k].edl);
      chk($sformatf("row%0d fault", k), {31'd0, fault}, 0);
      cyc();
    end

    // timeout: TIMEOUT=4, BUSY forever -> five strobe cycles, then ERR
    idle_inputs();
    iREN = 1; iaddr = 32'h500; ramstate = B;
    @(negedge CLK);
    chk("tmo idle strobe", {31'd0, ramREN}, 0);
    n = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      @(negedge CLK);
      if (fault) begin seen = 1; break; end
      if (ramREN) n++;
    end
    chk("tmo fault seen", {31'd0, seen}, 1);
    chk("tmo wait cycles", n, 5);
    chk("tmo err strobes", {30'd0, ramREN, ramWEN}, 0);
    chk("tmo err hits", {30'd0, ihit, dhit}, 0);
    dWEN = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge CLK);
      chk($sformatf("err lock %0d", i), {29'd0, ramREN | ramWEN, ihit | dhit, fault}, 32'd1);
    end
    cyc();
    RST = 1;
    cyc();
    @(negedge CLK);
    chk("tmo rst fault", {31'd0, fault}, 0);
    chk("tmo rst strobes", {30'd0, ramREN, ramWEN}, 0);
    chk("tmo rst iload", iload, 0);
    cyc();
    RST = 0;
    idle_inputs();

    // RAM error during a data read
    dREN = 1; daddr = 32'h600;
    @(negedge CLK);
    cyc();
    ramstate = E;
    @(negedge CLK);
    chk("err dreq strobe", {31'd0, ramREN}, 1);
    chk("err dreq fault", {31'd0, fault}, 0);
    cyc();
    ramstate = F;
    @(negedge CLK);
    chk("err fault", {31'd0, fault}, 1);
    chk("err no dhit", {31'd0, dhit}, 0);
    chk("err strobe", {31'd0, ramREN}, 0);
    dREN = 0; iREN = 1; ramstate = A;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge CLK);
      chk($sformatf("err ignore %0d", i), {29'd0, ramREN | ramWEN, ihit | dhit, fault}, 32'd1);
    end
    cyc();
    RST = 1;
    cyc();
    RST = 0;
    idle_inputs();

    // reset in the middle of a granted read wins over ACCESS
    dREN = 1; daddr = 32'h700;
    @(negedge CLK);
    cyc();
    ramstate = A; ramload = 32'hABABABAB; RST = 1;
    @(negedge CLK);
    chk("mid rst strobe", {31'd0, ramREN}, 1);
    cyc();
    @(negedge CLK);
    chk("mid rst hits", {30'd0, ihit, dhit}, 0);
    chk("mid rst dload", dload, 0);
    chk("mid rst strobes", {30'd0, ramREN, ramWEN}, 0);
    cyc();
    RST = 0;
    idle_inputs();
    cyc();
    @(negedge CLK);
    chk("post rst hits", {30'd0, ihit, dhit}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, which is the maximum number of cycles a granted request waits for ramstate==ACCESS before fault.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL expose these ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction fetch request
- iaddr  in  32  fetch address
- iload  out  32  fetched word, registered
- ihit  out  1  one-cycle fetch-complete pulse to hazard logic
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read word, registered
- dhit  out  1  one-cycle data-complete pulse to hazard logic
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
- fault  out  1  sticky error flag

Function
REQ-004 The FSM SHALL have the states IDLE, IREQ, DREQ, RESP and ERR.
REQ-005 In IDLE with (dREN|dWEN)=1, the FSM SHALL go to DREQ next cycle; else with iREN=1, to IREQ; else it SHALL stay in IDLE.
REQ-006 Data SHALL always have priority over fetch when both requests are pending in IDLE.
REQ-007 If dREN and dWEN are both 1, the request SHALL be treated as a write.
REQ-008 In IREQ the block SHALL drive ramREN=1, ramWEN=0 and ramaddr=iaddr.
REQ-009 In DREQ the block SHALL drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN and ramREN=dREN&~dWEN.
REQ-010 In all other states the block SHALL drive ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-011 In IREQ/DREQ with ramstate==ACCESS, the block SHALL go to RESP and latch ramload into iload (IREQ) or into dload (DREQ read); a write SHALL leave dload unchanged.
REQ-012 In RESP the block SHALL assert exactly one of ihit/dhit for exactly one cycle, matching the completed request, then return to IDLE.
REQ-013 Latency: request first seen in IDLE at cycle N, RAM strobes from N+1, ACCESS at cycle M SHALL produce the hit at M+1.
REQ-014 The minimum request-to-hit latency SHALL be 2 cycles.
REQ-015 Back-to-back requests SHALL incur one IDLE cycle between RESP and the next grant.
REQ-016 ihit and dhit SHALL never be asserted in the same cycle.
REQ-017 Abort: in IREQ with iREN=0, or in DREQ with dREN=dWEN=0, and ramstate!=ACCESS, the block SHALL return to IDLE without a hit and without updating iload or dload.
REQ-018 Abort SHALL take precedence over timeout in the same cycle.
REQ-019 An 8-bit wait counter SHALL clear on entry to IREQ/DREQ and increment each cycle in those states while ramstate!=ACCESS.
REQ-020 When the wait counter equals TIMEOUT, the block SHALL go to ERR.
REQ-021 The wait counter SHALL saturate and never wrap.
REQ-022 In IREQ/DREQ, ramstate==ERROR SHALL send the FSM to ERR on the next cycle.
REQ-023 When ACCESS and timeout coincide, ACCESS SHALL win.
REQ-024 On entering ERR, fault SHALL be set to 1 and held.
REQ-025 In ERR, no RAM strobes and no hits SHALL be issued.
REQ-026 ERR SHALL be exited only by RST.
REQ-027 ramstate in IDLE/RESP SHALL be ignored.

Reset
REQ-028 With RST=1 at a rising edge, the block SHALL set state=IDLE, ihit=0, dhit=0, fault=0, iload=0, dload=0 and the wait counter to 0.
REQ-029 RST mid-transaction SHALL abort it with no hit.
REQ-030 RAM strobes SHALL be 0 in the cycle after the reset edge.
REQ-031 RST SHALL take priority over every other input.

Verification
REQ-032 Fetch: iREN=1, iaddr=0x40, ramstate ACCESS on 2nd strobe cycle with ramload=0x8C220004 -> ihit one cycle later, iload=0x8C220004, dhit=0.
REQ-033 Priority: iREN=1 and dREN=1 (daddr=0x100) in the same IDLE cycle -> DREQ first with ramaddr=0x100; after dhit, one IDLE cycle, then IREQ with ramaddr=iaddr.
REQ-034 Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ACCESS after 3 BUSY cycles -> ramWEN=1 and ramstore=0xDEADBEEF for 4 cycles, dhit pulse, dload unchanged.
REQ-035 Abort: iREN dropped in 2nd IREQ cycle with ramstate BUSY -> IDLE next cycle, no ihit, iload unchanged.
REQ-036 Timeout: TIMEOUT=4, ramstate held BUSY -> ERR after 4 waiting cycles, fault=1, strobes 0; RST=1 -> fault=0, IDLE.
REQ-037 Error: ramstate=ERROR during DREQ -> fault=1 next cycle, no dhit, later requests ignored until RST.
